// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter and sequencer that shares one UART
// transmitter among NREQ byte requesters. It latches the granted byte and
// drives opcode 41 until the transmitter reports the frame finished, then
// forces a non-41 gap for one baud tick so the transmitter re-arms.
// Optional frame watchdog: define TXARB_TIMEOUT_EN to build it.
//
// state  | meaning
// IDLE   | no frame; Req sampled, round-robin grant on any request
// LAUNCH | opcode=41, waiting for the transmitter to drop TxDone
// SEND   | opcode=41, frame in progress, waiting for TxDone to rise
// GAP    | opcode=0, waiting for one baud tick rise before next grant
module tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    tick,
  input  logic [NREQ-1:0]         Req,
  input  logic [8*NREQ-1:0]       ReqData,
  input  logic                    TxDone,
  output logic [NREQ-1:0]         Ack,
  output logic [NREQ-1:0]         Done,
  output logic [5:0]              opcode,
  output logic [7:0]              Data,
  output logic [$clog2(NREQ)-1:0] GrantId,
  output logic                    Busy,
  output logic                    Timeout
);

  localparam int         IW    = $clog2(NREQ);
  localparam logic [5:0] OP_TX = 6'd41;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SEND, S_GAP} state_t;

  state_t          r_state;
  logic            r_tick_q;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_grant;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_done;
  logic [5:0]      r_opcode;
  logic [7:0]      r_data;
  logic            r_busy;
  logic            r_timeout;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_last_nxt;
  logic [IW-1:0]   w_grant_nxt;
  logic [NREQ-1:0] w_ack_nxt;
  logic [NREQ-1:0] w_done_nxt;
  logic [5:0]      w_opcode_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_timeout_nxt;
  logic            w_grant_now;
  logic            w_tick_rise;
  logic            w_any;
  logic [IW-1:0]   w_sel;
  logic            w_tmo_hit;

  assign w_tick_rise = tick & ~r_tick_q;

  // Round-robin search: first set Req starting just after the last grant
  always_comb begin : rr_search
    logic [IW-1:0] v_idx;
    w_any = 1'b0;
    w_sel = '0;
    v_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = IW'((int'(r_last) + k) % NREQ);
      if (!w_any && Req[v_idx]) begin
        w_any = 1'b1;
        w_sel = v_idx;
      end
    end
  end

`ifdef TXARB_TIMEOUT_EN
  logic [31:0] r_tcnt;

  // Frame watchdog: cleared on grant, counts every cycle in LAUNCH and SEND
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tcnt <= '0;
    end else if (w_grant_now) begin
      r_tcnt <= '0;
    end else if (r_state == S_LAUNCH || r_state == S_SEND) begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign w_tmo_hit = (r_state == S_LAUNCH || r_state == S_SEND) &&
                     (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_opcode_nxt  = r_opcode;
    w_data_nxt    = r_data;
    w_ack_nxt     = '0;
    w_done_nxt    = '0;
    w_timeout_nxt = 1'b0;
    w_grant_now   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_opcode_nxt = '0;
        if (w_any) begin
          w_grant_now      = 1'b1;
          w_ack_nxt[w_sel] = 1'b1;
          w_data_nxt       = ReqData[{w_sel, 3'b000} +: 8];
          w_grant_nxt      = w_sel;
          w_last_nxt       = w_sel;
          w_opcode_nxt     = OP_TX;
          w_state_nxt      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_opcode_nxt = OP_TX;
        if (w_tmo_hit) begin
          w_opcode_nxt  = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_GAP;
        end else if (!TxDone) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_opcode_nxt = OP_TX;
        // A frame that completes on the watchdog's last cycle still counts as done
        if (TxDone) begin
          w_opcode_nxt         = '0;
          w_done_nxt[r_grant]  = 1'b1;
          w_state_nxt          = S_GAP;
        end else if (w_tmo_hit) begin
          w_opcode_nxt  = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        w_opcode_nxt = '0;
        if (w_tick_rise) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_opcode_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, grant pointer and tick edge history
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tick_q  <= 1'b0;
      r_last    <= IW'(NREQ - 1);
      r_grant   <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_opcode  <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_tick_q  <= tick;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_done    <= w_done_nxt;
      r_opcode  <= w_opcode_nxt;
      r_data    <= w_data_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_timeout <= w_timeout_nxt;
    end
  end

  assign Ack     = r_ack;
  assign Done    = r_done;
  assign opcode  = r_opcode;
  assign Data    = r_data;
  assign GrantId = r_grant;
  assign Busy    = r_busy;
  assign Timeout = r_timeout;

endmodule

// File: tb/tb_tx_arbiter.sv
// Testbench for tx_arbiter with a behavioural UART transmitter attached.
// Expected grants, Done pulses and serialized bytes are queued by each
// scenario before stimulus and checked when the DUT / transmitter produce them.
module tb_tx_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        tick;
  logic [3:0]  Req;
  logic [31:0] ReqData;
  logic        TxDone;
  logic [3:0]  Ack;
  logic [3:0]  Done;
  logic [5:0]  opcode;
  logic [7:0]  Data;
  logic [1:0]  GrantId;
  logic        Busy;
  logic        Timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cyc_txdone = 0;
  int n_done   = 0;
  int n_tmo    = 0;
  int n_viol   = 0;
  bit m_force  = 1'b0;

  int         exp_ack_id[$];
  logic [7:0] exp_ack_data[$];
  int         exp_done[$];
  logic [7:0] exp_tx[$];

  tx_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(50)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .tick(tick), .Req(Req), .ReqData(ReqData),
    .TxDone(TxDone), .Ack(Ack), .Done(Done), .opcode(opcode), .Data(Data),
    .GrantId(GrantId), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
    end
  end

  // Baud tick: period 4 Clk, high 2 / low 2, synchronous to Clk
  initial begin : tick_gen
    int ph;
    ph = 0;
    tick = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      ph = (ph + 1) % 4;
      tick = (ph < 2);
    end
  end

  // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit
  initial begin : tx_model
    bit         rise;
    bit         m_tq;
    bit         m_busy;
    bit         m_armed;
    bit         m_line;
    int         m_bitn;
    logic [7:0] m_shr;
    logic [7:0] m_rx;
    logic [7:0] e;
    TxDone = 1'b1;
    m_tq = 1'b0; m_busy = 1'b0; m_armed = 1'b1; m_bitn = 0; m_line = 1'b1;
    m_shr = '0; m_rx = '0;
    forever begin
      @(posedge Clk);
      #2;
      rise = tick && !m_tq;
      m_tq = tick;
      if (m_force) begin
        TxDone = 1'b1; m_busy = 1'b0; m_armed = 1'b1;
      end else if (rise) begin
        if (opcode !== 6'd41) begin
          m_busy = 1'b0; m_armed = 1'b1; TxDone = 1'b1;
        end else if (m_busy) begin
          m_bitn++;
          if (m_bitn <= 8) begin
            m_line = m_shr[m_bitn-1];
            m_rx[m_bitn-1] = m_line;
          end else if (m_bitn == 9) begin
            m_line = 1'b1;
          end else begin
            m_busy = 1'b0; m_armed = 1'b0; TxDone = 1'b1; cyc_txdone = cyc;
            checks++;
            if (exp_tx.size() == 0) begin
              failures++;
              $display("FAIL tx_byte unexpected frame got=%h expected none", m_rx);
            end else begin
              e = exp_tx.pop_front();
              if (m_rx !== e) begin
                failures++;
                $display("FAIL tx_byte got=%h expected=%h", m_rx, e);
              end
            end
          end
        end else if (!m_armed) begin
          n_viol++;
        end else begin
          m_busy = 1'b1; TxDone = 1'b0; m_shr = Data; m_bitn = 0; m_line = 1'b0;
        end
      end
    end
  end

  // Output monitor: Ack/Done pulses checked against the scoreboard queues
  initial begin : monitor
    int         id;
    logic [7:0] d;
    logic [3:0] oh;
    forever begin
      @(negedge Clk);
      if (Rst_n === 1'b1 && Ack !== 4'b0000) begin
        checks++;
        if (exp_ack_id.size() == 0) begin
          failures++;
          $display("FAIL ack unexpected Ack=%b expected none", Ack);
        end else begin
          id = exp_ack_id.pop_front();
          d  = exp_ack_data.pop_front();
          oh = 4'b0001 << id;
          if (Ack !== oh || Data !== d || opcode !== 6'd41 || GrantId !== id[1:0] || Busy !== 1'b1) begin
            failures++;
            $display("FAIL ack got Ack=%b Data=%h op=%0d gid=%0d busy=%b expected Ack=%b Data=%h op=41 gid=%0d busy=1",
                     Ack, Data, opcode, GrantId, Busy, oh, d, id);
          end
        end
      end
      if (Rst_n === 1'b1 && Done !== 4'b0000) begin
        n_done++;
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL done unexpected Done=%b expected none", Done);
        end else begin
          id = exp_done.pop_front();
          oh = 4'b0001 << id;
          if (Done !== oh || opcode !== 6'd0 || Ack !== 4'b0000) begin
            failures++;
            $display("FAIL done got Done=%b op=%0d Ack=%b expected Done=%b op=0 Ack=0000", Done, opcode, Ack, oh);
          end
        end
        checks++;
        if (cyc - cyc_txdone !== 1) begin
          failures++;
          $display("FAIL opcode_fall got=%0d cycles after TxDone rise expected=1", cyc - cyc_txdone);
        end
      end
      if (Timeout === 1'b1) n_tmo++;
    end
  end

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Ack === 4'b0000 && n < 500);
    if (Ack === 4'b0000) begin
      checks++; failures++;
      $display("FAIL %s ack_wait got=no Ack in %0d cycles expected=Ack", name, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (Busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL %s idle_wait got=Busy after %0d cycles expected=idle", name, n);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b1; Req = '0; ReqData = '0;
    #2 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (opcode !== 6'd0)  begin failures++; $display("FAIL reset_opcode got=%0d expected=0", opcode); end
    checks++;
    if (Data !== 8'h00)   begin failures++; $display("FAIL reset_data got=%h expected=00", Data); end
    checks++;
    if (Ack !== 4'b0000 || Done !== 4'b0000) begin
      failures++; $display("FAIL reset_pulses got Ack=%b Done=%b expected 0000/0000", Ack, Done);
    end
    checks++;
    if (GrantId !== 2'd0) begin failures++; $display("FAIL reset_grantid got=%0d expected=0", GrantId); end
    checks++;
    if (Busy !== 1'b0 || Timeout !== 1'b0) begin
      failures++; $display("FAIL reset_busy_tmo got Busy=%b Timeout=%b expected 0/0", Busy, Timeout);
    end
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_single();
    int lat;
    int d0;
    exp_ack_id.push_back(0); exp_ack_data.push_back(8'hA5);
    exp_done.push_back(0);   exp_tx.push_back(8'hA5);
    d0 = n_done;
    @(negedge Clk);
    ReqData[7:0] = 8'hA5;
    Req = 4'b0001;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (Ack[0] !== 1'b1 && lat < 20);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL single_ack_latency got=%0d expected=1", lat); end
    Req = 4'b0000;
    wait_idle("single");
    checks++;
    if (n_done - d0 !== 1) begin failures++; $display("FAIL single_done_count got=%0d expected=1", n_done - d0); end
  endtask

  task automatic test_priority();
    ReqData = {8'h44, 8'h33, 8'h22, 8'h11};
    exp_ack_id.push_back(3); exp_ack_data.push_back(8'h44); exp_done.push_back(3); exp_tx.push_back(8'h44);
    exp_ack_id.push_back(0); exp_ack_data.push_back(8'h11); exp_done.push_back(0); exp_tx.push_back(8'h11);
    exp_ack_id.push_back(3); exp_ack_data.push_back(8'h44); exp_done.push_back(3); exp_tx.push_back(8'h44);
    @(negedge Clk);
    Req = 4'b1000;
    wait_ack("priority_g3");
    Req = 4'b1001;
    wait_ack("priority_g0");
    Req = 4'b1000;
    wait_ack("priority_g3b");
    Req = 4'b0000;
    wait_idle("priority");
  endtask

  task automatic test_back_to_back();
    int ids[5] = '{0, 1, 2, 3, 0};
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = ReqData[8*ids[i] +: 8];
      exp_ack_id.push_back(ids[i]); exp_ack_data.push_back(b);
      exp_done.push_back(ids[i]);   exp_tx.push_back(b);
    end
    @(negedge Clk);
    Req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack("b2b");
    Req = 4'b0000;
    wait_idle("b2b");
  endtask

  task automatic test_reqdata_change();
    int n;
    ReqData[15:8] = 8'h3C;
    exp_ack_id.push_back(1); exp_ack_data.push_back(8'h3C);
    exp_done.push_back(1);   exp_tx.push_back(8'h3C);
    @(negedge Clk);
    Req = 4'b0010;
    wait_ack("reqdata");
    Req = 4'b0000;
    ReqData[15:8] = 8'hFF;
    n = 0;
    while (TxDone !== 1'b0 && n < 50) begin @(negedge Clk); n++; end
    repeat (5) @(negedge Clk);
    checks++;
    if (Data !== 8'h3C || opcode !== 6'd41) begin
      failures++; $display("FAIL reqdata_hold got Data=%h op=%0d expected Data=3C op=41", Data, opcode);
    end
    wait_idle("reqdata");
    ReqData[15:8] = 8'h22;
  endtask

  task automatic test_reset_midframe();
    int n;
    exp_ack_id.push_back(2); exp_ack_data.push_back(8'h33);
    @(negedge Clk);
    Req = 4'b0100;
    wait_ack("rstmid");
    Req = 4'b0000;
    n = 0;
    while (TxDone !== 1'b0 && n < 50) begin @(negedge Clk); n++; end
    repeat (6) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    checks++;
    if (opcode !== 6'd0 || Busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got op=%0d Busy=%b expected op=0 Busy=0", opcode, Busy);
    end
    checks++;
    if (Data !== 8'h00 || GrantId !== 2'd0 || Ack !== 4'b0000 || Done !== 4'b0000) begin
      failures++; $display("FAIL rstmid_regs got Data=%h gid=%0d Ack=%b Done=%b expected 00/0/0000/0000",
                           Data, GrantId, Ack, Done);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (8) @(negedge Clk);
    exp_ack_id.push_back(0); exp_ack_data.push_back(8'h11);
    exp_done.push_back(0);   exp_tx.push_back(8'h11);
    Req = 4'b1001;
    wait_ack("rstmid_first");
    Req = 4'b0000;
    wait_idle("rstmid");
  endtask

`ifdef TXARB_TIMEOUT_EN
  task automatic test_timeout();
    int ca;
    int n;
    int d0;
    d0 = n_done;
    m_force = 1'b1;
    exp_ack_id.push_back(1); exp_ack_data.push_back(8'h22);
    @(negedge Clk);
    Req = 4'b0010;
    wait_ack("timeout");
    ca = cyc;
    Req = 4'b0000;
    n = 0;
    while (Timeout !== 1'b1 && n < 200) begin @(negedge Clk); n++; end
    checks++;
    if (Timeout !== 1'b1 || cyc - ca !== 50) begin
      failures++; $display("FAIL timeout_delay got Timeout=%b after %0d cycles expected pulse after 50", Timeout, cyc - ca);
    end
    @(negedge Clk);
    checks++;
    if (Timeout !== 1'b0 || opcode !== 6'd0) begin
      failures++; $display("FAIL timeout_width got Timeout=%b op=%0d expected 0/0", Timeout, opcode);
    end
    n = 0;
    while (Busy !== 1'b0 && n < 10) begin @(negedge Clk); n++; end
    checks++;
    if (Busy !== 1'b0 || n_done !== d0) begin
      failures++; $display("FAIL timeout_idle got Busy=%b done_pulses=%0d expected 0/0", Busy, n_done - d0);
    end
    m_force = 1'b0;
    repeat (6) @(negedge Clk);
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=time limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int exp_tmo;
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_reqdata_change();
    test_reset_midframe();
`ifdef TXARB_TIMEOUT_EN
    test_timeout();
    exp_tmo = 1;
`else
    exp_tmo = 0;
`endif
    repeat (4) @(negedge Clk);
    checks++;
    if (n_tmo !== exp_tmo) begin failures++; $display("FAIL timeout_count got=%0d expected=%0d", n_tmo, exp_tmo); end
    checks++;
    if (n_viol !== 0) begin failures++; $display("FAIL tick_after_done got=%0d expected=0", n_viol); end
    checks++;
    if (exp_ack_id.size() != 0 || exp_done.size() != 0 || exp_tx.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got ack=%0d done=%0d tx=%0d expected 0/0/0",
               exp_ack_id.size(), exp_done.size(), exp_tx.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter and sequencer for the UART transmitter. It shares one transmitter among NREQ byte requesters. It latches the granted byte and drives the transmitter's `opcode`/`Data` inputs with the transmit opcode (41). It watches `TxDone` to find the end of each frame, then forces a non-41 opcode gap so the transmitter re-arms before the next grant.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 200000: `Clk` cycles allowed per frame before abort. Used only with `TXARB_TIMEOUT_EN`.
- `Clk`  in  1  system clock; all state updates on its rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  baud tick, the same signal that clocks the transmitter.
  - Synchronous to `Clk`.
  - High and low each for ≥2 `Clk` cycles.
- `Req`  in  NREQ  per-requester request level.
- `ReqData`  in  8*NREQ  requester i byte on bits [8i+7:8i].
- `TxDone`  in  1  transmitter done flag: 1 = idle or finished, 0 = frame in progress.
- `Ack`  out  NREQ  one-cycle pulse: byte of requester i latched.
- `Done`  out  NREQ  one-cycle pulse: frame of requester i completed.
- `opcode`  out  6  to transmitter: 6'd41 while sending, 6'd0 otherwise.
- `Data`  out  8  latched byte to transmitter.
- `GrantId`  out  $clog2(NREQ)  index of current or last grant.
- `Busy`  out  1  high in every state except IDLE.
- `Timeout`  out  1  one-cycle abort pulse; constant 0 without `TXARB_TIMEOUT_EN`.

## Operation
- All outputs are registered.
- Reset values:
  - `opcode`=0, `Data`=0, `Ack`=0, `Done`=0, `GrantId`=0, `Busy`=0, `Timeout`=0.
  - State = IDLE.
  - Round-robin pointer `Last`=NREQ-1, so requester 0 wins first.
- `tick_q` registers `tick`. A tick rise (`tickRise`) is `tick & ~tick_q`.
- IDLE:
  - If any `Req` bit is set, grant the first set index searching from (`Last`+1) mod NREQ upward with wrap.
  - Same edge: `Data`←that byte, `Ack[i]`=1, `GrantId`=i, `Last`=i, `opcode`←41. Go to LAUNCH.
- LAUNCH: hold `opcode`=41. Stay until `TxDone` is sampled 0, then go to SEND.
- SEND: hold `opcode`=41. On `TxDone` sampled 1:
  - `opcode`←0 and `Done[GrantId]`=1 on the same edge.
  - Go to GAP.
- GAP: `opcode`=0. On the first `tickRise` seen in GAP, go to IDLE. The transmitter has then sampled a non-41 opcode and reset its frame state.
- `Req` is sampled only in IDLE.
  - A `Req` held high after `Ack` counts as a new request for the next byte.
  - One byte is sent per `Ack`.
- `ReqData` is sampled only on the grant edge. Later changes do not affect the frame in flight.
- `Req` bits that rise and fall entirely outside IDLE are lost. Requesters hold `Req` until `Ack`.
- Simultaneous requests are resolved purely by the rotating pointer. No requester waits more than NREQ-1 grants.
- Reset mid-frame: outputs return to reset values immediately. The transmitter aborts its frame at its next `tick`.

## Timing
- `Req` sampled high in IDLE at edge N gives `Ack`, `opcode`=41 and `Data` valid after edge N.
- `TxDone` sampled 1 in SEND at edge M gives `opcode`=0 and `Done` after edge M.
- `opcode` falls one `Clk` after the `TxDone` rise. This is well before the next `tick` edge, so the transmitter never starts an unintended second frame.
- Minimum spacing between consecutive grants is one `tick` period after `Done`, plus 1 `Clk` for the IDLE decision.
- `Ack` and `Done` pulse exactly one cycle each and never overlap for the same requester.

## Configuration
- `TXARB_TIMEOUT_EN` defined:
  - A counter clears on entry to LAUNCH and counts every `Clk` in LAUNCH and SEND.
  - When the count reaches `TIMEOUT_CYCLES`-1: `opcode`←0, `Timeout`=1 for one cycle, no `Done` pulse, go to GAP.
- `TXARB_TIMEOUT_EN` not defined:
  - No counter is built and `Timeout` is tied to 0.
  - LAUNCH and SEND wait indefinitely for `TxDone`.

## Test plan
- Single request, real transmitter attached, NREQ=4, `tick` period 4 `Clk`, `Req`=4'b0001, byte 8'hA5.
  - `Ack[0]` is set on the next edge and `opcode`=41.
  - The transmitter serializes 0xA5 LSB first.
  - `Done[0]` pulses once and `opcode` returns to 0 one `Clk` after the `TxDone` rise.
- All four requesters held high with bytes 11/22/33/44.
  - Grants run 0,1,2,3,0.
  - No `tickRise` occurs with `opcode`=41 after `TxDone` rises.
- `Req`=4'b1000 after a grant to requester 3 while `Req[0]` is also set: next grant is 0, then 3.
- `Rst_n` pulled low mid-frame (SEND):
  - `opcode`=0 and `Busy`=0 asynchronously.
  - After release, requester 0 is granted first.
- `TXARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=50, `TxDone` forced to 1:
  - `Timeout` pulses exactly 50 cycles after `Ack`.
  - No `Done` pulse; IDLE is reached after the next `tickRise`.
- Requester changes `ReqData` during SEND: transmitted byte equals the value latched at `Ack`.
